accum3_seq: RTL and testbench
=============================

ACCUM3_SEQ -- requirements
Module: accum3_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand/accumulator width in bits.
REQ-002 The block SHALL have parameter SATURATE, default 0; 1 clamps the accumulator on carry-out.
REQ-003 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  command/operand present.
REQ-006 in_ready  output  1  block accepts a command this cycle.
REQ-007 in_cmd  input  2  00 ADD, 01 ADC (add with stored carry), 10 LOAD, 11 CLR.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 acc  output  WIDTH  accumulator value.
REQ-012 carry  output  1  carry-out of the last ADD/ADC, else 0.
REQ-013 ovf  output  1  sticky overflow flag.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, CALC, RESULT.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid&in_ready at edge k registers in_cmd/in_data, next state CALC.
REQ-016 CALC: in_ready=0, out_valid=0; at edge k+1 acc/carry/ovf update per REQ-019..023, next state RESULT.
REQ-017 RESULT: in_ready=0, out_valid=1; out_valid&out_ready at edge m returns to IDLE, so in_ready=1 from cycle m+1.
REQ-018 Latency: out_valid SHALL assert in the cycle after edge k+1; minimum issue interval is 3 cycles.
REQ-019 ADD: {carry,acc} SHALL equal acc + in_data, computed as a WIDTH-bit ripple of full-adder stages with carry-in 0.
REQ-020 ADC: as ADD but carry-in equal to the stored carry value.
REQ-021 LOAD: acc=in_data, carry=0; ovf unchanged.
REQ-022 CLR: acc=0, carry=0, ovf=0; in_data ignored.
REQ-023 ovf SHALL set on any ADD/ADC with carry-out 1 and hold until CLR or Reset.
REQ-024 SATURATE=1 with ADD/ADC carry-out 1: acc SHALL be all ones, carry=1, ovf=1.
REQ-025 in_valid, in_cmd and in_data SHALL be ignored in CALC and RESULT.
REQ-026 acc, carry and ovf SHALL hold stable while out_valid=1 and out_ready=0, and also in IDLE.
REQ-027 out_ready SHALL be ignored outside RESULT.
REQ-028 Wrap-around: with SATURATE=0, the sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-029 Reset=1 at an edge SHALL force state IDLE, acc=0, carry=0, ovf=0, out_valid=0, in_ready=1 after that edge.
REQ-030 Reset SHALL take priority over every handshake, including in CALC or RESULT; an in-flight command is discarded with no result.
REQ-031 A command offered in the same cycle as Reset=1 SHALL NOT be accepted.

Verification
REQ-032 Reset, LOAD 3, ADD 2 -> acc=5, carry=0, ovf=0; out_valid 2 cycles after acceptance.
REQ-033 LOAD 6, ADD 3 -> acc=1, carry=1, ovf=1; then ADC 0 -> acc=2, carry=0, ovf=1.
REQ-034 SATURATE=1: LOAD 7, ADD 1 -> acc=7, carry=1, ovf=1; then CLR -> acc=0, carry=0, ovf=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in RESULT with in_valid toggling -> out_valid=1, acc/carry constant, in_ready=0, no command accepted; out_ready=1 -> IDLE next cycle.
REQ-036 Reset asserted while in CALC after ADD 4 following LOAD 4 -> next cycle acc=0, carry=0, out_valid=0, in_ready=1, and no result is produced.
REQ-037 Wrap: LOAD 5, ADD 5 (SATURATE=0) -> acc=2, carry=1, ovf=1.

Source files
------------

// File: rtl/accum3_seq.sv
// Handshaked accumulator: one command per IDLE->CALC->RESULT pass, with a
// ripple-carry add path, sticky overflow and optional saturation.
module accum3_seq #(
  parameter int unsigned WIDTH    = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  localparam logic [1:0] CMD_ADD  = 2'b00;
  localparam logic [1:0] CMD_ADC  = 2'b01;
  localparam logic [1:0] CMD_LOAD = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             in_ready_d;
  logic             out_valid_d;
  logic [1:0]       cmd_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Next-state logic; handshake outputs are registered decodes of the next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    state_d = RESULT;
      RESULT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == RESULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Ripple of full-adder stages; carry-in is the stored carry only for ADC
  always_comb begin
    logic cy;
    cy  = (cmd_q == CMD_ADC) ? carry : 1'b0;
    sum = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i] = acc[i] ^ data_q[i] ^ cy;
      cy     = (acc[i] & data_q[i]) | (cy & (acc[i] ^ data_q[i]));
    end
    cout = cy;
  end

  // Command capture on acceptance in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= CMD_CLR;
      data_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      cmd_q  <= in_cmd;
      data_q <= in_data;
    end
  end

  // Architectural state changes only in CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (state_q == CALC) begin
      case (cmd_q)
        CMD_ADD, CMD_ADC: begin
          acc   <= (SATURATE && cout) ? {WIDTH{1'b1}} : sum;
          carry <= cout;
          if (cout) ovf <= 1'b1;
        end
        CMD_LOAD: begin
          acc   <= data_q;
          carry <= 1'b0;
        end
        default: begin
          acc   <= '0;
          carry <= 1'b0;
          ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum3_seq.sv
// Directed bench for accum3_seq: one wrapping and one saturating instance share
// the same stimulus; expected values are hand-computed for WIDTH=3.
module tb_accum3_seq;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] ADC  = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_cmd;
  logic [2:0] in_data;
  logic       out_ready;

  logic       rdy0, ov0, cy0, of0;
  logic [2:0] acc0;
  logic       rdy1, ov1, cy1, of1;
  logic [2:0] acc1;

  int ncomp = 0;
  int nfail = 0;
  int lat   = 0;

  always #5 clk = ~clk;

  accum3_seq #(.WIDTH(3), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_cmd(in_cmd), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .acc(acc0), .carry(cy0), .ovf(of0)
  );

  accum3_seq #(.WIDTH(3), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_cmd(in_cmd), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .acc(acc1), .carry(cy1), .ovf(of1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [2:0] a, input logic c, input logic o);
    chk({tag, ".acc"},   8'(acc0), 8'(a));
    chk({tag, ".carry"}, 8'(cy0),  8'(c));
    chk({tag, ".ovf"},   8'(of0),  8'(o));
  endtask

  task automatic chk1(input string tag, input logic [2:0] a, input logic c, input logic o);
    chk({tag, ".sat.acc"},   8'(acc1), 8'(a));
    chk({tag, ".sat.carry"}, 8'(cy1),  8'(c));
    chk({tag, ".sat.ovf"},   8'(of1),  8'(o));
  endtask

  // Offer one command and wait (bounded) until its result is presented
  task automatic issue(input logic [1:0] c, input logic [2:0] d);
    int n;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) chk("issue.in_ready", 8'(rdy0), 8'd1);
    in_valid = 1'b1;
    in_cmd   = c;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ov0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!ov0) chk("issue.out_valid", 8'(ov0), 8'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop.in_ready",  8'(rdy0), 8'd1);
    chk("pop.out_valid", 8'(ov0),  8'd0);
  endtask

  task automatic op(input logic [1:0] c, input logic [2:0] d);
    issue(c, d);
    pop();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cmd = ADD; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready",  8'(rdy0), 8'd1);
    chk("rst.out_valid", 8'(ov0),  8'd0);
    chk0("rst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // LOAD 3, ADD 2 with latency check
    op(LOAD, 3'd3);
    chk0("load3", 3'd3, 1'b0, 1'b0);
    issue(ADD, 3'd2);
    chk("add2.latency", 8'(lat), 8'd2);
    chk("add2.in_ready", 8'(rdy0), 8'd0);
    chk0("add2", 3'd5, 1'b0, 1'b0);
    chk1("add2", 3'd5, 1'b0, 1'b0);
    pop();

    // Carry out, then ADC consuming the stored carry
    op(LOAD, 3'd6);
    issue(ADD, 3'd3);
    chk0("add3", 3'd1, 1'b1, 1'b1);
    chk1("add3", 3'd7, 1'b1, 1'b1);
    pop();
    issue(ADC, 3'd0);
    chk0("adc0", 3'd2, 1'b0, 1'b1);
    chk1("adc0", 3'd7, 1'b1, 1'b1);
    pop();
    op(CLR, 3'd5);
    chk0("clr_a", 3'd0, 1'b0, 1'b0);

    // Saturation on the SATURATE=1 instance, wrap on the other
    op(LOAD, 3'd7);
    issue(ADD, 3'd1);
    chk1("sat71", 3'd7, 1'b1, 1'b1);
    chk0("wrap71", 3'd0, 1'b1, 1'b1);
    pop();
    issue(CLR, 3'd7);
    chk1("clr_b", 3'd0, 1'b0, 1'b0);
    chk0("clr_b", 3'd0, 1'b0, 1'b0);
    pop();

    // Backpressure in RESULT while new commands are offered
    op(LOAD, 3'd1);
    issue(ADD, 3'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_cmd   = LOAD;
      in_data  = 3'd7;
      @(negedge clk);
      chk("bp.out_valid", 8'(ov0),  8'd1);
      chk("bp.in_ready",  8'(rdy0), 8'd0);
      chk0("bp", 3'd2, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    pop();
    @(negedge clk);
    chk("bp.idle_out_valid", 8'(ov0), 8'd0);
    chk0("bp_after", 3'd2, 1'b0, 1'b0);

    // Wrap-around, then LOAD keeps ovf
    op(LOAD, 3'd5);
    issue(ADD, 3'd5);
    chk0("wrap55", 3'd2, 1'b1, 1'b1);
    pop();
    op(LOAD, 3'd1);
    chk0("load_keeps_ovf", 3'd1, 1'b0, 1'b1);

    // Reset while a command is in CALC
    op(LOAD, 3'd4);
    in_valid = 1'b1; in_cmd = ADD; in_data = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rcalc.out_valid", 8'(ov0),  8'd0);
    chk("rcalc.in_ready",  8'(rdy0), 8'd1);
    chk0("rcalc", 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rcalc.no_result", 8'(ov0), 8'd0);
    end
    chk0("rcalc_hold", 3'd0, 1'b0, 1'b0);

    // Command offered together with reset is not taken
    op(LOAD, 3'd3);
    rst = 1'b1; in_valid = 1'b1; in_cmd = LOAD; in_data = 3'd5;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rcmd.in_ready", 8'(rdy0), 8'd1);
    @(negedge clk);
    chk("rcmd.out_valid", 8'(ov0), 8'd0);
    chk0("rcmd", 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
